tiny_dnn_core_fx: RTL and testbench

//  Fixed-point, parametrised successor of the single-lane DNN MAC core. Holds two weight banks
//  (ping-pong: one loads while the other computes) and runs a 2-stage pipelined

---
 rtl/tiny_dnn_core_fx_pkg.sv | 33 +++
 rtl/tiny_dnn_core_fx_if.sv | 38 +++
 rtl/tiny_dnn_wram.sv | 28 ++
 rtl/tiny_dnn_core_fx.sv | 170 +++++++++++++++++
 tb/tb_tiny_dnn_core_fx.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_dnn_core_fx_pkg.sv
// Shared types, defaults and the saturation helper for the fixed-point DNN MAC core.
// Saturation is evaluated on a wide signed value so any accumulator width up to SAT_W-2 fits.
package tiny_dnn_pkg;

    localparam int DW_DEF = 16;
    localparam int FB_DEF = 8;
    localparam int AW_DEF = 40;
    localparam int SAT_W  = 128;

    typedef logic signed [DW_DEF-1:0] data_t;
    typedef logic signed [AW_DEF-1:0] acc_t;
    typedef logic signed [SAT_W-1:0]  wide_t;

    // Pipeline operation tag; encoding order doubles as stage-2 priority (init > bias > exec)
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_EXEC = 2'd1,
        OP_BIAS = 2'd2,
        OP_INIT = 2'd3
    } op_e;

    // Clamp x to the range of a w-bit signed number
    function automatic wide_t sat_signed(input wide_t x, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 32'd1)) - wide_t'(1);
        lo = ~hi;
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/tiny_dnn_core_fx_if.sv
// Control, weight-load, operand and chain signals of one tiny_dnn_core_fx lane.
interface tiny_dnn_core_fx_if #(
    parameter int DW = 16,
    parameter int AB = 10
);
    logic                 init;
    logic                 write;
    logic                 bwrite;
    logic                 wbank;
    logic [AB-1:0]        wa;
    logic signed [DW-1:0] wd;
    logic                 exec;
    logic                 bias;
    logic                 rbank;
    logic [AB-1:0]        ra;
    logic signed [DW-1:0] d;
    logic                 relu;
    logic                 outr;
    logic                 update;
    logic signed [DW-1:0] sum_in;
    logic signed [DW-1:0] sum;
    logic                 ovf;

    modport master (
        output init, write, bwrite, wbank, wa, wd,
        output exec, bias, rbank, ra, d,
        output relu, outr, update, sum_in,
        input  sum, ovf
    );

    modport slave (
        input  init, write, bwrite, wbank, wa, wd,
        input  exec, bias, rbank, ra, d,
        input  relu, outr, update, sum_in,
        output sum, ovf
    );

endinterface

// File: rtl/tiny_dnn_wram.sv
// One weight bank: simple dual-port RAM, one synchronous write port and one
// synchronous read port with read enable. Contents are not reset.
module tiny_dnn_wram #(
    parameter int DW    = 16,
    parameter int FSIZE = 1024,
    parameter int AB    = $clog2(FSIZE)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AB-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AB-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [FSIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tiny_dnn_core_fx.sv
// Fixed-point DNN MAC lane: ping-pong weight banks, 2-stage pipelined multiply-accumulate
// with bias, AW-bit saturation, sticky overflow, optional ReLU and an output chain register.
module tiny_dnn_core_fx
    import tiny_dnn_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int FB    = FB_DEF,
    parameter int AW    = AW_DEF,
    parameter int FSIZE = 1024,
    parameter int AB    = $clog2(FSIZE)
) (
    input logic               clk,
    input logic               rst,
    tiny_dnn_core_fx_if.slave bus
);

    localparam logic [AB-1:0] BIAS_ADDR = AB'(FSIZE - 1);

    // Stage 0: bank access decode
    logic                 wr_req;
    logic                 rd_req;
    logic [AB-1:0]        wr_addr;
    logic [AB-1:0]        rd_addr;
    logic [1:0]           wr_en;
    logic [1:0]           rd_en;
    logic [DW-1:0]        rdata [2];
    op_e                  op0;

    // Pipeline registers
    op_e                  op1;
    op_e                  op2;
    logic                 rbank1;
    logic signed [DW-1:0] d_s1;
    logic signed [DW-1:0] d1;
    logic signed [DW-1:0] w1;

    // Accumulator, flags, chain
    logic signed [AW-1:0] acc;
    logic                 ovf_q;
    logic signed [DW-1:0] chain;

    // Stage 2 arithmetic
    logic signed [2*DW-1:0] prod;
    wide_t                  addend;
    wide_t                  cand;
    wide_t                  satv;
    logic                   sat_hit;

    // Output scaling
    logic signed [AW-1:0] t;
    logic signed [DW-1:0] scaled;

    always_comb begin
        wr_req  = bus.write | bus.bwrite;
        wr_addr = bus.bwrite ? BIAS_ADDR : bus.wa;
        rd_req  = bus.exec | bus.bias;
        rd_addr = bus.bias ? BIAS_ADDR : bus.ra;

        op0 = OP_NONE;
        if (bus.init) begin
            op0 = OP_INIT;
        end else if (bus.bias) begin
            op0 = OP_BIAS;
        end else if (bus.exec) begin
            op0 = OP_EXEC;
        end

        // A write to the bank being read wins; the read is dropped for that cycle
        for (int unsigned b = 0; b < 2; b++) begin
            wr_en[b] = wr_req && (bus.wbank == 1'(b));
            rd_en[b] = rd_req && (bus.rbank == 1'(b)) && !wr_en[b];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        tiny_dnn_wram #(
            .DW    (DW),
            .FSIZE (FSIZE),
            .AB    (AB)
        ) u_wram (
            .clk   (clk),
            .we    (wr_en[g]),
            .waddr (wr_addr),
            .wdata (bus.wd),
            .re    (rd_en[g]),
            .raddr (rd_addr),
            .rdata (rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op1 <= OP_NONE;
            op2 <= OP_NONE;
        end else begin
            op1 <= op0;
            op2 <= op1;
        end
        rbank1 <= bus.rbank;
        if (bus.exec) begin
            d_s1 <= bus.d;
        end
        if (op1 == OP_EXEC) begin
            d1 <= d_s1;
        end
        if (op1 == OP_EXEC || op1 == OP_BIAS) begin
            w1 <= rbank1 ? rdata[1] : rdata[0];
        end
    end

    always_comb begin
        prod   = w1 * d1;
        addend = '0;
        if (op2 == OP_EXEC) begin
            addend = wide_t'(prod);
        end else if (op2 == OP_BIAS) begin
            addend = wide_t'(w1) <<< FB;
        end
        cand    = wide_t'(acc) + addend;
        satv    = sat_signed(cand, AW);
        sat_hit = (satv != cand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (op2)
                OP_INIT: begin
                    acc   <= '0;
                    ovf_q <= 1'b0;
                end
                OP_EXEC, OP_BIAS: begin
                    acc <= AW'(satv);
                    if (sat_hit) begin
                        ovf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else if (bus.outr) begin
            chain <= bus.sum_in;
        end
    end

    // Back to the Q(DW-FB).FB activation format, clamped to DW bits
    always_comb begin
        t      = acc >>> FB;
        scaled = DW'(sat_signed(wide_t'(t), DW));
        if (bus.relu && t[AW-1]) begin
            scaled = '0;
        end
    end

    assign bus.sum = bus.update ? scaled : chain;
    assign bus.ovf = ovf_q;

    // A read of the bank being written leaves the stage-1 weight undefined
    a_rw_collision: assert property (
        @(posedge clk) disable iff (rst) !(rd_req && wr_req && (bus.wbank == bus.rbank))
    );

endmodule

// File: tb/tb_tiny_dnn_core_fx.sv
// Self-checking bench for tiny_dnn_core_fx: table vectors, a due-cycle scoreboard on the
// main lane, a 32-bit-accumulator lane for overflow and a three-lane output chain.
module tb_tiny_dnn_core_fx;
    import tiny_dnn_pkg::*;

    localparam int DW    = 16;
    localparam int FB    = 8;
    localparam int FSIZE = 1024;
    localparam int AB    = 10;
    localparam int CFS   = 16;
    localparam int CAB   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    tiny_dnn_core_fx_if #(.DW(DW), .AB(AB))  bus ();
    tiny_dnn_core_fx_if #(.DW(DW), .AB(AB))  bus32 ();
    tiny_dnn_core_fx_if #(.DW(DW), .AB(CAB)) ch0 ();
    tiny_dnn_core_fx_if #(.DW(DW), .AB(CAB)) ch1 ();
    tiny_dnn_core_fx_if #(.DW(DW), .AB(CAB)) ch2 ();

    tiny_dnn_core_fx #(.DW(DW), .FB(FB), .AW(40), .FSIZE(FSIZE), .AB(AB)) u_dut (
        .clk(clk), .rst(rst), .bus(bus));
    tiny_dnn_core_fx #(.DW(DW), .FB(FB), .AW(32), .FSIZE(FSIZE), .AB(AB)) u_dut32 (
        .clk(clk), .rst(rst), .bus(bus32));
    tiny_dnn_core_fx #(.DW(DW), .FB(FB), .AW(40), .FSIZE(CFS), .AB(CAB)) u_ch0 (
        .clk(clk), .rst(rst), .bus(ch0));
    tiny_dnn_core_fx #(.DW(DW), .FB(FB), .AW(40), .FSIZE(CFS), .AB(CAB)) u_ch1 (
        .clk(clk), .rst(rst), .bus(ch1));
    tiny_dnn_core_fx #(.DW(DW), .FB(FB), .AW(40), .FSIZE(CFS), .AB(CAB)) u_ch2 (
        .clk(clk), .rst(rst), .bus(ch2));

    assign ch1.sum_in = ch0.sum;
    assign ch2.sum_in = ch1.sum;

    // ---------------- checking and scoreboard ----------------
    typedef struct {
        int          due;
        logic [15:0] sum;
        logic        ovf;
        string       tag;
    } sb_t;
    sb_t sb[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [15:0] s, input logic o);
        sb_t e;
        e.due = cyc + 3;
        e.sum = s;
        e.ovf = o;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        sb_t e;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, "_sum"}, bus.sum, e.sum);
            check({e.tag, "_ovf"}, 16'(bus.ovf), 16'(e.ovf));
        end
    end

    // ---------------- main-lane reference model ----------------
    localparam longint AHI = (longint'(1) <<< 39) - 1;
    localparam longint ALO = -AHI - 1;
    longint            macc;
    logic              movf;
    logic signed [15:0] mw [2][FSIZE];

    task automatic m_add(input longint v);
        macc = macc + v;
        if (macc > AHI) begin macc = AHI; movf = 1'b1; end
        if (macc < ALO) begin macc = ALO; movf = 1'b1; end
    endtask

    function automatic logic [15:0] m_sum(input logic relu_i);
        longint t;
        t = macc >>> 8;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        if (relu_i && t < 0) t = 0;
        return 16'(t);
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_ops();
        bus.init = 0; bus.write = 0; bus.bwrite = 0; bus.exec = 0; bus.bias = 0; bus.outr = 0;
        bus32.init = 0; bus32.write = 0; bus32.bwrite = 0; bus32.exec = 0; bus32.bias = 0;
        bus32.outr = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_ops();
    endtask

    task automatic do_write(input logic bank, input int addr, input logic [15:0] v);
        bus.write = 1; bus.wbank = bank; bus.wa = AB'(addr); bus.wd = v;
        mw[bank][addr] = v;
    endtask

    task automatic do_exec(input logic bank, input int addr, input logic [15:0] dv);
        bus.exec = 1; bus.rbank = bank; bus.ra = AB'(addr); bus.d = dv;
        m_add(longint'(mw[bank][addr]) * longint'($signed(dv)));
    endtask

    task automatic do_init();
        bus.init = 1;
        macc = 0;
        movf = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 16) begin
            step();
            k++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d results never produced, required 0 pending", sb.size());
            sb.delete();
        end
    endtask

    // ---------------- vector tables ----------------
    typedef struct { int ra; logic [15:0] d; logic [15:0] exp; } t1_t;
    typedef struct {
        logic [15:0] bw;
        int          mode;      // 0 bwrite, 1 write at FSIZE-1, 2 write+bwrite
        logic        relu;
        logic        with_exec;
        logic [15:0] exp;
    } t2_t;
    typedef struct {
        logic [15:0] sin;
        logic        outr;
        logic        upd1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] e2;
    } t5_t;

    t1_t t1[4];
    t2_t t2[6];
    t5_t t5[6];

    initial begin
        logic [15:0] r;

        t1[0] = '{ra: 0, d: 16'h0100, exp: 16'h0100};
        t1[1] = '{ra: 1, d: 16'h0200, exp: 16'h0300};
        t1[2] = '{ra: 2, d: 16'h0300, exp: 16'h0600};
        t1[3] = '{ra: 3, d: 16'h0400, exp: 16'h0A00};

        t2[0] = '{bw: 16'hFF80, mode: 0, relu: 1'b0, with_exec: 1'b0, exp: 16'hFF80};
        t2[1] = '{bw: 16'hFF80, mode: 0, relu: 1'b1, with_exec: 1'b0, exp: 16'h0000};
        t2[2] = '{bw: 16'h7FFF, mode: 1, relu: 1'b0, with_exec: 1'b0, exp: 16'h7FFF};
        t2[3] = '{bw: 16'h8000, mode: 2, relu: 1'b0, with_exec: 1'b1, exp: 16'h8000};
        t2[4] = '{bw: 16'h8000, mode: 0, relu: 1'b1, with_exec: 1'b0, exp: 16'h0000};
        t2[5] = '{bw: 16'h0180, mode: 1, relu: 1'b1, with_exec: 1'b1, exp: 16'h0180};

        t5[0] = '{sin: 16'h1234, outr: 1'b1, upd1: 1'b0, e0: 16'h1234, e1: 16'h0000, e2: 16'h0000};
        t5[1] = '{sin: 16'h5678, outr: 1'b1, upd1: 1'b0, e0: 16'h5678, e1: 16'h1234, e2: 16'h0000};
        t5[2] = '{sin: 16'h9ABC, outr: 1'b1, upd1: 1'b0, e0: 16'h9ABC, e1: 16'h5678, e2: 16'h1234};
        t5[3] = '{sin: 16'hFFFF, outr: 1'b0, upd1: 1'b0, e0: 16'h9ABC, e1: 16'h5678, e2: 16'h1234};
        t5[4] = '{sin: 16'h0001, outr: 1'b1, upd1: 1'b1, e0: 16'h0001, e1: 16'h0000, e2: 16'h0000};
        t5[5] = '{sin: 16'h0002, outr: 1'b1, upd1: 1'b0, e0: 16'h0002, e1: 16'h0001, e2: 16'h9ABC};

        macc = 0;
        movf = 1'b0;
        bus.wbank = 0; bus.wa = '0; bus.wd = '0; bus.rbank = 0; bus.ra = '0; bus.d = '0;
        bus.relu = 0; bus.update = 0; bus.sum_in = '0;
        bus32.wbank = 0; bus32.wa = '0; bus32.wd = '0; bus32.rbank = 0; bus32.ra = '0;
        bus32.d = '0; bus32.relu = 0; bus32.update = 0; bus32.sum_in = '0;
        idle_ops();
        ch0.init = 0; ch0.write = 0; ch0.bwrite = 0; ch0.wbank = 0; ch0.wa = '0; ch0.wd = '0;
        ch0.exec = 0; ch0.bias = 0; ch0.rbank = 0; ch0.ra = '0; ch0.d = '0; ch0.relu = 0;
        ch0.outr = 0; ch0.update = 0; ch0.sum_in = '0;
        ch1.init = 0; ch1.write = 0; ch1.bwrite = 0; ch1.wbank = 0; ch1.wa = '0; ch1.wd = '0;
        ch1.exec = 0; ch1.bias = 0; ch1.rbank = 0; ch1.ra = '0; ch1.d = '0; ch1.relu = 0;
        ch1.outr = 0; ch1.update = 0;
        ch2.init = 0; ch2.write = 0; ch2.bwrite = 0; ch2.wbank = 0; ch2.wa = '0; ch2.wd = '0;
        ch2.exec = 0; ch2.bias = 0; ch2.rbank = 0; ch2.ra = '0; ch2.d = '0; ch2.relu = 0;
        ch2.outr = 0; ch2.update = 0;

        // Reset state
        repeat (3) step();
        check("rst_sum_chain", bus.sum, 16'h0000);
        check("rst_ovf", 16'(bus.ovf), 16'h0000);
        check("rst32_ovf", 16'(bus32.ovf), 16'h0000);
        rst = 0;
        bus.update = 1;
        bus32.update = 1;
        step();
        check("rst_sum_acc", bus.sum, 16'h0000);

        // 1: dot product of four unit weights with 1..4
        for (int i = 0; i < 4; i++) begin
            do_write(0, i, 16'h0100);
            step();
        end
        do_init();
        for (int i = 0; i < 4; i++) begin
            step();
            do_exec(0, t1[i].ra, t1[i].d);
            sb_push($sformatf("t1_mac%0d", i), t1[i].exp, 1'b0);
        end
        step();
        wait_drain();

        // 2: bias slot writes, bias step, ReLU
        do_write(1, 3, 16'h0100);
        step();
        for (int i = 0; i < 6; i++) begin
            bus.wbank = 1; bus.wd = t2[i].bw; bus.relu = t2[i].relu;
            if (t2[i].mode == 1) begin
                bus.write = 1; bus.wa = AB'(FSIZE - 1);
            end else if (t2[i].mode == 2) begin
                bus.write = 1; bus.bwrite = 1; bus.wa = AB'(3);
            end else begin
                bus.bwrite = 1; bus.wa = AB'(7);
            end
            step();
            bus.init = 1;
            step();
            bus.bias = 1; bus.rbank = 1; bus.ra = AB'(7); bus.d = 16'h5555;
            if (t2[i].with_exec) bus.exec = 1;
            sb_push($sformatf("t2_bias%0d", i), t2[i].exp, 1'b0);
            step();
            wait_drain();
        end
        bus.relu = 0;
        do_init();
        step();
        do_exec(1, 3, 16'h0100);
        sb_push("t2_addr3_kept", 16'h0100, 1'b0);
        step();
        wait_drain();

        // 3: full-scale products, 40-bit vs 32-bit accumulator
        do_write(0, 5, 16'h7FFF);
        bus32.write = 1; bus32.wbank = 0; bus32.wa = AB'(5); bus32.wd = 16'h7FFF;
        step();
        do_init();
        bus32.init = 1;
        for (int i = 0; i < 300; i++) begin
            step();
            do_exec(0, 5, 16'h7FFF);
            bus32.exec = 1; bus32.rbank = 0; bus32.ra = AB'(5); bus32.d = 16'h7FFF;
            if (i == 299) sb_push("t3_aw40", 16'h7FFF, 1'b0);
        end
        step();
        wait_drain();
        check("t3_aw32_ovf", 16'(bus32.ovf), 16'h0001);
        check("t3_aw32_sum", bus32.sum, 16'h7FFF);
        bus32.init = 1;
        repeat (3) step();
        check("t3_init_clr_ovf", 16'(bus32.ovf), 16'h0000);
        check("t3_init_clr_sum", bus32.sum, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            bus32.exec = 1; bus32.rbank = 0; bus32.ra = AB'(5); bus32.d = 16'h8000;
            step();
        end
        repeat (3) step();
        check("t3_neg_ovf", 16'(bus32.ovf), 16'h0001);
        check("t3_neg_sum", bus32.sum, 16'h8000);

        // 4: back-to-back MACs on one bank while the other bank is rewritten
        for (int i = 16; i < 32; i++) begin
            r = 16'($urandom_range(1023)) - 16'd512;
            do_write(0, i, r);
            step();
        end
        do_init();
        for (int i = 0; i < 40; i++) begin
            step();
            r = 16'($urandom_range(4095)) - 16'd2048;
            do_exec(0, 16 + (i % 16), r);
            r = 16'($urandom_range(1023)) - 16'd512;
            do_write(1, 32 + i, r);
            bus.outr = 1;
            bus.sum_in = 16'($urandom);
            sb_push($sformatf("t4a_%0d", i), m_sum(1'b0), movf);
        end
        step();
        do_init();
        for (int i = 0; i < 40; i++) begin
            step();
            r = 16'($urandom_range(4095)) - 16'd2048;
            do_exec(1, 32 + i, r);
            r = 16'($urandom_range(1023)) - 16'd512;
            do_write(0, 100 + i, r);
            sb_push($sformatf("t4b_%0d", i), m_sum(1'b0), movf);
        end
        step();
        wait_drain();

        // 5: three-lane output chain
        for (int i = 0; i < 6; i++) begin
            ch0.sum_in = t5[i].sin;
            ch0.outr = t5[i].outr; ch1.outr = t5[i].outr; ch2.outr = t5[i].outr;
            ch1.update = t5[i].upd1;
            step();
            check($sformatf("t5_c0_%0d", i), ch0.sum, t5[i].e0);
            check($sformatf("t5_c1_%0d", i), ch1.sum, t5[i].e1);
            check($sformatf("t5_c2_%0d", i), ch2.sum, t5[i].e2);
        end
        ch0.outr = 0; ch1.outr = 0; ch2.outr = 0; ch1.update = 0;

        // 6: reset one cycle after an exec drops it
        do_init();
        step();
        do_exec(0, 0, 16'h0200);
        sb_push("t6_pre", 16'h0200, 1'b0);
        step();
        wait_drain();
        bus.exec = 1; bus.rbank = 0; bus.ra = AB'(0); bus.d = 16'h0300;
        step();
        rst = 1;
        step();
        rst = 0;
        check("t6_rst_sum", bus.sum, 16'h0000);
        check("t6_rst_ovf", 16'(bus.ovf), 16'h0000);
        check("t6_rst32_ovf", 16'(bus32.ovf), 16'h0000);
        repeat (3) step();
        check("t6_dropped", bus.sum, 16'h0000);
        macc = 0;
        movf = 1'b0;
        do_exec(0, 0, 16'h0300);
        sb_push("t6_fresh", 16'h0300, 1'b0);
        step();
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
